// File: rtl/tdm_demux4_if.sv
// Serial slot link between the 4:1 TDM mux and the demultiplexer.
// The master drives one slot sample per valid beat; sync marks slot 0.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;

  modport master (output din, output din_valid, output sync);
  modport slave  (input  din, input  din_valid, input  sync);
endinterface

// File: rtl/tdm_demux4.sv
// Recovers channels A..D from a slot-interleaved stream, checking frame
// alignment against the sync marker and emitting each complete frame in parallel.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  tdm_demux4_if.slave      link,
  input  logic             err_clr,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             S1,
  output logic             S0,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       slot_reg, slot_next;
  logic [WIDTH-1:0] shadow_reg [0:2];
  logic [WIDTH-1:0] shadow_next [0:2];
  logic [WIDTH-1:0] chan_reg [0:3];
  logic [WIDTH-1:0] chan_next [0:3];
  logic             fv_reg, fv_next;
  logic             err_reg, err_next;
  logic             err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      slot_reg  <= 2'd0;
      fv_reg    <= 1'b0;
      err_reg   <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_reg[i] <= '0;
      for (int i = 0; i < 4; i++) chan_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      fv_reg    <= fv_next;
      err_reg   <= err_next;
      for (int i = 0; i < 3; i++) shadow_reg[i] <= shadow_next[i];
      for (int i = 0; i < 4; i++) chan_reg[i] <= chan_next[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    fv_next    = 1'b0;
    err_set    = 1'b0;
    for (int i = 0; i < 3; i++) shadow_next[i] = shadow_reg[i];
    for (int i = 0; i < 4; i++) chan_next[i] = chan_reg[i];

    if (link.din_valid) begin
      case (state_reg)
        IDLE: begin
          if (link.sync) begin
            shadow_next[0] = link.din;
            slot_next      = 2'd1;
            state_next     = RUN;
          end
        end
        RUN: begin
          if (slot_reg == 2'd0) begin
            if (link.sync) begin
              shadow_next[0] = link.din;
              slot_next      = 2'd1;
            end else begin
              // Lost alignment: drop the beat and hunt for the next marker.
              err_set    = 1'b1;
              state_next = IDLE;
              slot_next  = 2'd0;
            end
          end else if (link.sync) begin
            // Early marker aborts the partial frame and restarts at slot 0.
            err_set        = 1'b1;
            shadow_next[0] = link.din;
            slot_next      = 2'd1;
          end else if (slot_reg == 2'd3) begin
            chan_next[0] = shadow_reg[0];
            chan_next[1] = shadow_reg[1];
            chan_next[2] = shadow_reg[2];
            chan_next[3] = link.din;
            slot_next    = 2'd0;
            fv_next      = 1'b1;
          end else begin
            if (slot_reg == 2'd1) shadow_next[1] = link.din;
            else                  shadow_next[2] = link.din;
            slot_next = slot_reg + 2'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // A new error on the same edge as err_clr keeps the flag set.
    err_next = err_set | (err_reg & ~err_clr);
  end

  assign A           = chan_reg[0];
  assign B           = chan_reg[1];
  assign C           = chan_reg[2];
  assign D           = chan_reg[3];
  assign S1          = slot_reg[1];
  assign S0          = slot_reg[0];
  assign frame_valid = fv_reg;
  assign locked      = (state_reg == RUN);
  assign sync_err    = err_reg;

endmodule
